// File: rtl/apb_pkg.sv
// Shared APB slave definitions: access FSM states, address alignment and strobe expansion.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Byte-address bits below the word index.
    localparam int ADDR_LSB   = 2;
    localparam int MAX_STRB_W = 32;

    // Expand one strobe bit per byte into a full bit mask; callers truncate to their bus width.
    function automatic logic [8*MAX_STRB_W-1:0] strb_to_mask(input logic [MAX_STRB_W-1:0] strb);
        logic [8*MAX_STRB_W-1:0] mask;
        mask = '0;
        for (int k = 0; k < MAX_STRB_W; k++) begin
            mask[8*k +: 8] = {8{strb[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// Reusable APB slave access sequencer: tracks setup/access phases, inserts wait states,
// and flags the cycle where a transfer completes.
module apb_slave_fsm
    import apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic psel_i,
    input  logic penable_i,
    output logic pready_o,
    output logic commit_o
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    apb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (!psel_i) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pready_o = (state_q == ACCESS) && (cnt_q == '0);
    assign commit_o = psel_i && penable_i && pready_o;

endmodule

// File: rtl/apb_reg_bank.sv
// Parametrised APB register file with byte strobes, wait states, read-only registers and PSLVERR.
// Optional privilege check on writes enabled by defining APB_REG_BANK_PROT_EN.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 8,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
`ifdef APB_REG_BANK_PROT_EN
    input  logic [2:0]                   PPROT,
`endif
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_val
);

    localparam int IDX_W = ADDR_W - ADDR_LSB;

    logic              commit;
    logic [IDX_W-1:0]  word_idx;
    logic              in_range;
    logic              misaligned;
    logic              ro_hit;
    logic              priv_err;
    logic              access_err;
    logic              wr_commit;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_mask;

    apb_slave_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fsm (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .psel_i    (PSEL),
        .penable_i (PENABLE),
        .pready_o  (PREADY),
        .commit_o  (commit)
    );

    assign word_idx   = PADDR[ADDR_W-1:ADDR_LSB];
    assign in_range   = int'(word_idx) < NUM_REGS;
    assign misaligned = PADDR[ADDR_LSB-1:0] != '0;

    always_comb begin
        ro_hit  = 1'b0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (word_idx == IDX_W'(i)) begin
                ro_hit  = RO_MASK[i];
                rd_word = reg_q[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_REG_BANK_PROT_EN
    assign priv_err = PWRITE && !PPROT[0];
`else
    assign priv_err = 1'b0;
`endif

    assign access_err = !in_range || misaligned || (PWRITE && ro_hit) || priv_err;
    assign PSLVERR    = PREADY && access_err;
    assign PRDATA     = (PREADY && !PWRITE && !access_err) ? rd_word : '0;
    assign wr_commit  = commit && PWRITE && !access_err;
    assign wr_mask    = DATA_W'(strb_to_mask(MAX_STRB_W'(PSTRB)));

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_q[i*DATA_W +: DATA_W] = ro_val[i*DATA_W +: DATA_W];
        end else begin : g_rw
            logic [DATA_W-1:0] data_q, data_d;

            always_comb begin
                data_d = data_q;
                if (wr_commit && (word_idx == IDX_W'(i))) begin
                    data_d = (data_q & ~wr_mask) | (PWDATA & wr_mask);
                end
            end

            // NOTE: each register is a discrete flop bank, so it can and must take RESET_VAL on reset.
            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET) begin
                    data_q <= RESET_VAL;
                end else begin
                    data_q <= data_d;
                end
            end

            assign reg_q[i*DATA_W +: DATA_W] = data_q;
        end
    end

    // Writable-register slices of ro_val and the upper PPROT bits are intentionally ignored.
    logic unused_inputs;
`ifdef APB_REG_BANK_PROT_EN
    assign unused_inputs = ^{ro_val, PPROT[2:1]};
`else
    assign unused_inputs = ^ro_val;
`endif

endmodule

// File: tb/tb_apb_reg_bank.sv
// Scoreboard bench for apb_reg_bank: random APB traffic checked against an array model.
module tb_apb_reg_bank;

    localparam int              DW   = 32;
    localparam int              AW   = 8;
    localparam int              NR   = 8;
    localparam int              WAIT = 2;
    localparam logic [NR-1:0]   ROM  = 8'h41;
    localparam logic [DW-1:0]   RST  = 32'h0000_A5C3;

    logic             PCLK;
    logic             PRESET;
    logic [AW-1:0]    PADDR;
    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [DW-1:0]    PWDATA;
    logic [DW/8-1:0]  PSTRB;
`ifdef APB_REG_BANK_PROT_EN
    logic [2:0]       PPROT;
`endif
    logic [DW-1:0]    PRDATA;
    logic             PREADY;
    logic             PSLVERR;
    logic [NR*DW-1:0] reg_q;
    logic [NR*DW-1:0] ro_val;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mem [NR];
    int            checks   = 0;
    int            failures = 0;

    apb_reg_bank #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .NUM_REGS    (NR),
        .WAIT_CYCLES (WAIT),
        .RO_MASK     (ROM),
        .RESET_VAL   (RST)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
`ifdef APB_REG_BANK_PROT_EN
        .PPROT   (PPROT),
`endif
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .reg_q   (reg_q),
        .ro_val  (ro_val)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < NR; i++) begin
            if (!ROM[i]) check($sformatf("reg_q[%0d]", i), reg_q[i*DW +: DW], mem[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem[i] = RST;
    endtask

    // Monitor: compares every completed transfer against the head of the scoreboard.
    initial begin
        int   acc;
        exp_t e;
        acc = 0;
        forever begin
            @(negedge PCLK);
            if (PRESET || !(PSEL && PENABLE)) begin
                acc = 0;
            end else begin
                acc++;
                if (PREADY) begin
                    check("latency", acc, WAIT + 1);
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow: actual=response required=no_response");
                    end else begin
                        e = sb.pop_front();
                        check("prdata", PRDATA, e.rdata);
                        check("pslverr", PSLVERR, e.err);
                    end
                    acc = 0;
                end else begin
                    check("prdata_wait", PRDATA, 0);
                    check("pslverr_wait", PSLVERR, 0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Starts and ends at posedge+1; the model is updated and the expectation queued at issue.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                        input logic [3:0] strb, input logic [2:0] prot);
        exp_t e;
        int   idx;
        int   n;
        logic err;
        idx = int'(addr) >> 2;
        err = 1'b0;
        if (idx >= NR || addr[1:0] != 2'b00) err = 1'b1;
        else if (wr && ROM[idx]) err = 1'b1;
`ifdef APB_REG_BANK_PROT_EN
        if (wr && !prot[0]) err = 1'b1;
`endif
        e.err   = err;
        e.rdata = '0;
        if (!wr && !err) e.rdata = ROM[idx] ? ro_val[idx*DW +: DW] : mem[idx];
        if (wr && !err) begin
            for (int k = 0; k < 4; k++) if (strb[k]) mem[idx][8*k +: 8] = wd[8*k +: 8];
        end
        sb.push_back(e);

        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd; PSTRB = strb;
`ifdef APB_REG_BANK_PROT_EN
        PPROT = prot;
`endif
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PREADY && n < 64);
        if (!PREADY) begin
            checks++;
            failures++;
            $display("FAIL pready_timeout: actual=%0d_cycles required=%0d_cycles", n, WAIT + 1);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        check_regs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        logic [AW-1:0] addr;
        int            sel;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
        PWDATA = '0; PSTRB = '0;
`ifdef APB_REG_BANK_PROT_EN
        PPROT = 3'b001;
`endif
        ro_val = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ro_val[DW-1:0] = 32'h5A5A_5A5A;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_pready", PREADY, 0);
        check("reset_pslverr", PSLVERR, 0);
        check("reset_prdata", PRDATA, 0);
        check_regs();
        PRESET = 1'b0;
        idle(1);

        xfer(8'h04, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001);
        xfer(8'h04, 1'b0, 32'h0, 4'h0, 3'b001);
        check("reg1_slice", reg_q[1*DW +: DW], 32'hDEAD_BEEF);
        xfer(8'h08, 1'b1, 32'h1122_3344, 4'hF, 3'b001);
        xfer(8'h08, 1'b1, 32'hAABB_CCDD, 4'b0101, 3'b001);
        xfer(8'h08, 1'b0, 32'h0, 4'h0, 3'b001);
        check("strobe_merge", reg_q[2*DW +: DW], 32'h11BB_33DD);
        xfer(8'h20, 1'b1, 32'h0BAD_0BAD, 4'hF, 3'b001);
        xfer(8'h02, 1'b0, 32'h0, 4'h0, 3'b001);
        xfer(8'h00, 1'b1, 32'h1234_5678, 4'hF, 3'b001);
        xfer(8'h00, 1'b0, 32'h0, 4'h0, 3'b001);
        xfer(8'h0C, 1'b1, 32'hFFFF_FFFF, 4'h0, 3'b001);
        xfer(8'h1C, 1'b1, 32'hC001_D00D, 4'hF, 3'b001);
        xfer(8'h1C, 1'b0, 32'h0, 4'h0, 3'b001);
`ifdef APB_REG_BANK_PROT_EN
        xfer(8'h10, 1'b1, 32'h5555_AAAA, 4'hF, 3'b000);
        xfer(8'h10, 1'b1, 32'h6666_BBBB, 4'hF, 3'b001);
        xfer(8'h10, 1'b0, 32'h0, 4'h0, 3'b000);
`endif

        // Abort mid-wait: PSEL drops after one access cycle, nothing may be written.
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h14; PWRITE = 1'b1; PWDATA = 32'hABCD_EF01; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        idle(2);
        check_regs();
        xfer(8'h14, 1'b1, 32'h0F0F_0F0F, 4'hF, 3'b001);
        xfer(8'h14, 1'b0, 32'h0, 4'h0, 3'b001);

        // Reset during an access phase.
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h18; PWRITE = 1'b1; PWDATA = 32'h7777_7777; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        #1;
        check("midreset_pready", PREADY, 0);
        check("midreset_pslverr", PSLVERR, 0);
        model_reset();
        check_regs();
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        idle(1);
        xfer(8'h18, 1'b0, 32'h0, 4'h0, 3'b001);

        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      addr = AW'($urandom_range(0, NR - 1) * 4);
            else if (sel == 7) addr = AW'($urandom_range(NR, 63) * 4);
            else if (sel == 8) addr = AW'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else               addr = AW'($urandom);
            if (t % 37 == 0) ro_val = {$urandom, $urandom, $urandom, $urandom,
                                       $urandom, $urandom, $urandom, $urandom};
            xfer(addr, 1'($urandom), $urandom, 4'($urandom), 3'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
